// File: rtl/branch_hazard_scoreboard_pkg.sv
// hazard_pkg: scoreboard entry type, stage indices and forward-select encoding.
package hazard_pkg;
    localparam int AW_MAX  = 8;
    localparam int STG_EX  = 0;
    localparam int STG_MEM = 1;
    localparam int STG_WB  = 2;
    localparam int FWD_RF  = 0;
    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              mem_read;
        logic [AW_MAX-1:0] dst;
    } sb_entry_t;
    localparam sb_entry_t SB_BUBBLE = '0;
endpackage

// File: rtl/branch_hazard_scoreboard_src_resolver.sv
// branch_src_resolver: youngest-writer match, readiness and forward select for one branch source.
module branch_src_resolver
    import hazard_pkg::*;
#(
    parameter int AW         = 5,
    parameter int DEPTH      = 3,
    parameter int ALU_READY  = STG_MEM,
    parameter int LOAD_READY = STG_WB,
    parameter int SW         = 2
) (
    input  sb_entry_t         i_sb [DEPTH],
    input  logic [AW-1:0]     i_src,
    input  logic              i_en,
    output logic [SW-1:0]     o_sel,
    output logic              o_stall
);
    logic              w_hit;
    logic              w_load;
    logic              w_ready;
    logic              w_use;
    logic [SW-1:0]     w_k;
    logic [AW_MAX-1:0] w_src;
    assign w_src = AW_MAX'(i_src);
    // scan oldest to youngest so the lowest matching index is left standing
    always_comb begin
        w_hit  = 1'b0;
        w_load = 1'b0;
        w_k    = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (i_sb[k].valid && i_sb[k].reg_write && i_sb[k].dst == w_src) begin
                w_hit  = 1'b1;
                w_load = i_sb[k].mem_read;
                w_k    = SW'(k);
            end
        end
    end
    assign w_ready = w_load ? (w_k >= SW'(LOAD_READY)) : (w_k >= SW'(ALU_READY));
    assign w_use   = i_en & w_hit & (i_src != '0);
    assign o_sel   = (w_use & w_ready) ? w_k + SW'(1) : SW'(FWD_RF);
    assign o_stall = w_use & ~w_ready;
endmodule

// File: rtl/branch_hazard_scoreboard.sv
// branch_hazard_scoreboard: in-flight writer scoreboard driving ID-stage branch forwarding and stalls.
module branch_hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int AW         = 5,
    parameter int NSRC       = 2,
    parameter int DEPTH      = 3,
    parameter int ALU_READY  = STG_MEM,
    parameter int LOAD_READY = STG_WB,
    parameter int CNT_W      = 16,
    localparam int SW        = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_id_valid,
    input  logic                 i_id_is_branch,
    input  logic [NSRC*AW-1:0]   i_id_src,
    input  logic [AW-1:0]        i_id_dst,
    input  logic                 i_id_reg_write,
    input  logic                 i_id_mem_read,
    input  logic                 i_pipe_hold,
    input  logic                 i_flush,
    output logic                 o_br_stall,
    output logic [NSRC*SW-1:0]   o_fwd_sel,
    output logic [CNT_W-1:0]     o_stall_cycles
);
    sb_entry_t        r_sb [DEPTH];
    logic [CNT_W-1:0] r_cnt;
    logic [NSRC-1:0]  w_stall;
    logic             w_en;
    logic             w_take;
    sb_entry_t        w_id;
    assign w_en = i_id_valid & i_id_is_branch;
    genvar s;
    for (s = 0; s < NSRC; s++) begin : g_src
        branch_src_resolver #(
            .AW(AW), .DEPTH(DEPTH), .ALU_READY(ALU_READY), .LOAD_READY(LOAD_READY), .SW(SW)
        ) u_res (
            .i_sb(r_sb),
            .i_src(i_id_src[s*AW +: AW]),
            .i_en(w_en),
            .o_sel(o_fwd_sel[s*SW +: SW]),
            .o_stall(w_stall[s])
        );
    end
    assign o_br_stall     = w_en & (|w_stall);
    assign w_take         = i_id_valid & ~o_br_stall & ~i_flush;
    assign w_id           = '{valid: 1'b1, reg_write: i_id_reg_write, mem_read: i_id_mem_read,
                              dst: AW_MAX'(i_id_dst)};
    assign o_stall_cycles = r_cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) r_sb[k] <= SB_BUBBLE;
            r_cnt <= '0;
        end else if (!i_pipe_hold) begin
            r_sb[0] <= w_take ? w_id : SB_BUBBLE;
            for (int k = 1; k < DEPTH; k++) r_sb[k] <= r_sb[k-1];
            if (o_br_stall && r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
        end
    end
endmodule
